lsu_mem_ctrl: RTL



---
 rtl/lsu_mem_ctrl_pkg.sv | 32 +++
 rtl/lsu_mem_ctrl_if.sv | 24 ++
 rtl/lsu_mem_ctrl_align.sv | 53 +++++
 rtl/lsu_mem_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store unit and its lane aligner.
// Pure declarations: no latency, no flow control.
package lsu_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } st_funct3_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERR
  } lsu_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus: req/gnt address phase followed by an rvalid response (read data or write ack).
// The master holds req and the address-phase fields stable until gnt.
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            bus_req_o;
  logic            bus_gnt_i;
  logic            bus_we_o;
  logic [3:0]      bus_be_o;
  logic [XLEN-1:0] bus_addr_o;
  logic [XLEN-1:0] bus_wdata_o;
  logic            bus_rvalid_i;
  logic [XLEN-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Lane logic: byte enables, store-data replication, load extract/extend, legality checks.
// Purely combinational, no flow control.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    illegal    = we ? (funct3 > 3'b010) : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

    be        = 4'b1111;
    wdata_rep = wdata;
    if (we) begin
      case (funct3)
        SB: begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        SH: begin
          be        = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_rep = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end

    case (funct3)
      LB:      rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LBU:     rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one outstanding access on the data bus; done three cycles after accept at best.
// Stalls the core (busy) from accept until the cycle after done; requests are only sampled in IDLE.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_err_o,
  output logic [1:0]      lsu_err_cause_o,
  lsu_mem_ctrl_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state;
  logic [CW-1:0]   cnt;
  logic            cap_we;
  logic [2:0]      cap_funct3;
  logic [1:0]      cap_addr_lo;

  logic            idle;
  logic            sel_we;
  logic [2:0]      sel_funct3;
  logic [1:0]      sel_addr_lo;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rdata_ext;
  logic            misaligned;
  logic            illegal;

  // In IDLE the aligner looks at the live request so the legality decision is made on the accept edge.
  assign idle        = (state == IDLE);
  assign sel_we      = idle ? lsu_we_i          : cap_we;
  assign sel_funct3  = idle ? lsu_funct3_i      : cap_funct3;
  assign sel_addr_lo = idle ? lsu_addr_i[1:0]   : cap_addr_lo;
  assign lsu_busy_o  = !idle;

  lsu_align #(.XLEN(XLEN)) u_align (
    .we         (sel_we),
    .funct3     (sel_funct3),
    .addr_lo    (sel_addr_lo),
    .wdata      (lsu_wdata_i),
    .rdata      (bus.bus_rdata_i),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      cap_we          <= 1'b0;
      cap_funct3      <= '0;
      cap_addr_lo     <= '0;
      lsu_done_o      <= 1'b0;
      lsu_err_o       <= 1'b0;
      lsu_err_cause_o <= ERR_NONE;
      lsu_rdata_o     <= '0;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_be_o    <= '0;
      bus.bus_addr_o  <= '0;
      bus.bus_wdata_o <= '0;
    end else begin
      lsu_done_o      <= 1'b0;
      lsu_err_o       <= 1'b0;
      lsu_err_cause_o <= ERR_NONE;
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            cap_we      <= lsu_we_i;
            cap_funct3  <= lsu_funct3_i;
            cap_addr_lo <= lsu_addr_i[1:0];
            cnt         <= '0;
            if (illegal || misaligned) begin
              state           <= ERR;
              lsu_done_o      <= 1'b1;
              lsu_err_o       <= 1'b1;
              lsu_err_cause_o <= illegal ? ERR_ILLEGAL : ERR_MISALIGN;
            end else begin
              state           <= REQ;
              bus.bus_req_o   <= 1'b1;
              bus.bus_we_o    <= lsu_we_i;
              bus.bus_be_o    <= be;
              bus.bus_addr_o  <= {lsu_addr_i[XLEN-1:2], 2'b00};
              bus.bus_wdata_o <= wdata_rep;
            end
          end
        end
        REQ: begin
          if (bus.bus_gnt_i) begin
            state         <= WAIT;
            bus.bus_req_o <= 1'b0;
            cnt           <= '0;
          end else if (cnt == CNT_LAST) begin
            state           <= ERR;
            bus.bus_req_o   <= 1'b0;
            lsu_done_o      <= 1'b1;
            lsu_err_o       <= 1'b1;
            lsu_err_cause_o <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          if (bus.bus_rvalid_i) begin
            state      <= DONE;
            lsu_done_o <= 1'b1;
            if (!cap_we) begin
              lsu_rdata_o <= rdata_ext;
            end
          end else if (cnt == CNT_LAST) begin
            state           <= ERR;
            lsu_done_o      <= 1'b1;
            lsu_err_o       <= 1'b1;
            lsu_err_cause_o <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
